pulp_data_ram: RTL and testbench

PULP_DATA_RAM -- requirements
Module: pulp_data_ram

---
 rtl/pulp_data_ram.sv | 138 +++++++++++++
 tb/tb_pulp_data_ram.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pulp_data_ram.sv
// Single-port data RAM for a core data bus (req/gnt/rvalid protocol).
// Configurable grant and response wait states; out-of-range accesses return err.
module pulp_data_ram #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_WAIT  = 0,
  parameter int unsigned RESP_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [3:0]  GW   = 4'(GNT_WAIT);
  localparam logic [3:0]  RW   = 4'(RESP_WAIT);

  typedef enum logic [1:0] {IDLE, GWAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      gcnt_reg, gcnt_next;
  logic [3:0]      rcnt_reg, rcnt_next;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     offset;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic [3:0]      byte_we;
  logic            rd_ok_reg;
  logic            err_reg;
  logic [31:0]     rdata_reg;
  logic [31:0]     mem [DEPTH];

  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[AW+1:2];
  assign rvalid   = (state_reg == RESP) && (rcnt_reg == RW);

  always_comb begin
    state_next = state_reg;
    gcnt_next  = gcnt_reg;
    rcnt_next  = rcnt_reg;
    gnt        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (data_req_i) begin
          if (GW == 4'd0) begin
            gnt = 1'b1;
          end else begin
            // Counter includes the cycle that entered GWAIT, so gnt lands GNT_WAIT cycles later.
            state_next = GWAIT;
            gcnt_next  = 4'd1;
          end
        end
      end
      GWAIT: begin
        if (!data_req_i) begin
          state_next = IDLE;
          gcnt_next  = 4'd0;
        end else if (gcnt_reg == GW) begin
          gnt = 1'b1;
        end else begin
          gcnt_next = gcnt_reg + 4'd1;
        end
      end
      RESP: begin
        if (rvalid) begin
          state_next = IDLE;
          if (data_req_i) begin
            if (GW == 4'd0) begin
              gnt = 1'b1;
            end else begin
              state_next = GWAIT;
              gcnt_next  = 4'd1;
            end
          end
        end else begin
          rcnt_next = rcnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (gnt) begin
      state_next = RESP;
      gcnt_next  = 4'd0;
      rcnt_next  = 4'd0;
    end
    // Combinational grant must not leak out while reset is held.
    if (!rst_ni) gnt = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      gcnt_reg  <= 4'd0;
      rcnt_reg  <= 4'd0;
      rd_ok_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gcnt_reg  <= gcnt_next;
      rcnt_reg  <= rcnt_next;
      if (gnt) begin
        rd_ok_reg <= in_range && !data_we_i;
        err_reg   <= !in_range;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
      assign byte_we[gi] = gnt && in_range && data_we_i && data_be_i[gi];
    end
  endgenerate

  // Storage is never reset; read data is captured at the grant edge and held until rvalid.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
    end
    if (gnt && in_range && !data_we_i) rdata_reg <= mem[idx];
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid;
  assign data_rdata_o  = (rvalid && rd_ok_reg) ? rdata_reg : 32'd0;
  assign data_err_o    = rvalid && err_reg;

endmodule

// File: tb/tb_pulp_data_ram.sv
// Directed bench for pulp_data_ram: zero-wait instance for data/range/back-to-back,
// wait-state instance (GNT_WAIT=2, RESP_WAIT=3) for timing and reset corner cases.
module tb_pulp_data_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, req0, we0, gnt0, rvalid0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;
  logic        rst1_n, req1, we1, gnt1, rvalid1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  be1;

  pulp_data_ram #(.DEPTH(1024), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RESP_WAIT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .data_req_i(req0), .data_addr_i(addr0),
    .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wdata0), .data_gnt_o(gnt0),
    .data_rvalid_o(rvalid0), .data_rdata_o(rdata0), .data_err_o(err0)
  );

  pulp_data_ram #(.DEPTH(1024), .BASE_ADDR(32'h0), .GNT_WAIT(2), .RESP_WAIT(3)) dut1 (
    .clk_i(clk), .rst_ni(rst1_n), .data_req_i(req1), .data_addr_i(addr1),
    .data_we_i(we1), .data_be_i(be1), .data_wdata_i(wdata1), .data_gnt_o(gnt1),
    .data_rvalid_o(rvalid1), .data_rdata_o(rdata1), .data_err_o(err1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } b2b_t;

  vec_t vecs[15];
  b2b_t b2b[7];

  // Single access on the zero-wait instance: grant in the request cycle, rvalid the next.
  task automatic txn0(input int n, input vec_t v);
    @(negedge clk);
    req0 = 1'b1; we0 = v.we; addr0 = v.addr; be0 = v.be; wdata0 = v.wdata;
    #1;
    chk($sformatf("v%0d gnt", n), 32'(gnt0), 32'd1);
    chk($sformatf("v%0d rvalid_early", n), 32'(rvalid0), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    chk($sformatf("v%0d rvalid", n), 32'(rvalid0), 32'd1);
    chk($sformatf("v%0d rdata", n), rdata0, v.exp_rdata);
    chk($sformatf("v%0d err", n), 32'(err0), 32'(v.exp_err));
    $display("txn %0d: we=%0b addr=%h be=%h wdata=%h -> rdata=%h err=%0b",
             n, v.we, v.addr, v.be, v.wdata, rdata0, err0);
  endtask

  // Ten-cycle window on the wait-state instance; req held for cycles [0, drop).
  task automatic run_wait(input string name, input int drop, input logic we,
                          input logic [31:0] wdata, input int gc, input int rc,
                          input logic [31:0] exp_rdata);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req1 = (c < drop); we1 = we; addr1 = 32'h0; be1 = 4'hF; wdata1 = wdata;
      #1;
      chk($sformatf("%s c%0d gnt", name, c), 32'(gnt1), 32'(c == gc));
      chk($sformatf("%s c%0d rvalid", name, c), 32'(rvalid1), 32'(c == rc));
      chk($sformatf("%s c%0d rdata", name, c), rdata1, (c == rc) ? exp_rdata : 32'd0);
    end
    req1 = 1'b0;
    $display("wait seq %s: done", name);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h10,  4'hF, 32'h12345678, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,  4'hF, 32'h0,        32'h12345678, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,  4'h5, 32'hAABBCCDD, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h10,  4'hF, 32'h0,        32'h12BB56DD, 1'b0};
    vecs[4]  = '{1'b1, 32'h0,   4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h4,   4'hF, 32'h11111111, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 32'h8,   4'hF, 32'h22222222, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'hC,   4'hF, 32'h33333333, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,   4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[10] = '{1'b0, 32'h1000, 4'hF, 32'h0,       32'h0, 1'b1};
    vecs[11] = '{1'b1, 32'hFFC, 4'hF, 32'h0BADBEEF, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'hFFC, 4'hF, 32'h0,        32'h0BADBEEF, 1'b0};
    vecs[13] = '{1'b0, 32'h13,  4'hF, 32'h0,        32'h12BB56DD, 1'b0};
    vecs[14] = '{1'b1, 32'hFFFFFFFC, 4'hF, 32'h99999999, 32'h0, 1'b1};

    b2b[0] = '{1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 32'h0};
    b2b[1] = '{1'b1, 1'b0, 32'h4, 32'h0,        1'b1, 32'hCAFEF00D};
    b2b[2] = '{1'b1, 1'b0, 32'h8, 32'h0,        1'b1, 32'h11111111};
    b2b[3] = '{1'b1, 1'b0, 32'hC, 32'h0,        1'b1, 32'h22222222};
    b2b[4] = '{1'b1, 1'b1, 32'hC, 32'h44444444, 1'b1, 32'h33333333};
    b2b[5] = '{1'b1, 1'b0, 32'hC, 32'h0,        1'b1, 32'h0};
    b2b[6] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 32'h44444444};

    rst0_n = 1'b0; rst1_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; be0 = 4'hF; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0; be1 = 4'hF; wdata1 = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset gnt0", 32'(gnt0), 32'd0);
    chk("reset rvalid0", 32'(rvalid0), 32'd0);
    chk("reset rdata0", rdata0, 32'd0);
    chk("reset err0", 32'(err0), 32'd0);
    chk("reset gnt1", 32'(gnt1), 32'd0);
    chk("reset rvalid1", 32'(rvalid1), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    rst0_n = 1'b1; rst1_n = 1'b1;

    for (int i = 0; i < 15; i++) txn0(i, vecs[i]);

    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req0 = b2b[c].req; we0 = b2b[c].we; addr0 = b2b[c].addr; be0 = 4'hF; wdata0 = b2b[c].wdata;
      #1;
      chk($sformatf("b2b c%0d gnt", c), 32'(gnt0), 32'(b2b[c].req));
      chk($sformatf("b2b c%0d rvalid", c), 32'(rvalid0), 32'(b2b[c].exp_rvalid));
      chk($sformatf("b2b c%0d rdata", c), rdata0, b2b[c].exp_rdata);
      chk($sformatf("b2b c%0d err", c), 32'(err0), 32'd0);
      $display("b2b cycle %0d: gnt=%0b rvalid=%0b rdata=%h", c, gnt0, rvalid0, rdata0);
    end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    chk("b2b idle rvalid", 32'(rvalid0), 32'd0);

    run_wait("wait_wr", 3, 1'b1, 32'h5A5A5A5A, 2, 6, 32'h0);
    run_wait("wait_drop", 1, 1'b0, 32'h0, -1, -1, 32'h0);
    run_wait("wait_rd", 3, 1'b0, 32'h0, 2, 6, 32'h5A5A5A5A);

    // Read granted in cycle 2, reset one cycle after the grant.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0;
      #1;
      chk($sformatf("rst_seq c%0d gnt", c), 32'(gnt1), 32'(c == 2));
    end
    @(negedge clk);
    req1 = 1'b0;
    rst1_n = 1'b0;
    #1;
    chk("rst_mid gnt", 32'(gnt1), 32'd0);
    chk("rst_mid rvalid", 32'(rvalid1), 32'd0);
    chk("rst_mid rdata", rdata1, 32'd0);
    chk("rst_mid err", 32'(err1), 32'd0);
    repeat (2) @(negedge clk);
    rst1_n = 1'b1;
    $display("reset mid-transaction: released");
    run_wait("post_rst_idle", 0, 1'b0, 32'h0, -1, -1, 32'h0);
    run_wait("post_rst_rd", 3, 1'b0, 32'h0, 2, 6, 32'h5A5A5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
